// File: rtl/payload_pkg.sv
// rtl/payload_pkg.sv - shared types and elaboration-time sizing helpers for payload_axis_packer
// Contents: state_t FSM encoding, ceil_div/clog2, beat count, last-beat byte count and keep mask.
package payload_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        SEND = 2'd2
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Beats needed for payload plus optional checksum byte.
    function automatic int calc_nbeats(input int msg_bytes, input int data_bytes, input int csum_en);
        return ceil_div(msg_bytes + csum_en, data_bytes);
    endfunction

    function automatic int calc_last_bytes(input int msg_bytes, input int data_bytes, input int csum_en);
        return msg_bytes + csum_en - (calc_nbeats(msg_bytes, data_bytes, csum_en) - 1) * data_bytes;
    endfunction

    // Low n bits set; sized for the widest supported bus (64 bytes).
    function automatic logic [63:0] calc_last_keep(input int n);
        logic [63:0] k;
        k = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < n) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/payload_axis_packer_byte_sum.sv
// rtl/payload_axis_packer_byte_sum.sv - combinational modulo-256 sum of one stream chunk
// Ports: chunk (8*DATA_BYTES bits in), sum (8-bit out, carries beyond bit 7 dropped).
module payload_byte_sum
    import payload_pkg::*;
#(
    parameter int DATA_BYTES = 32
) (
    input  logic [8*DATA_BYTES-1:0] chunk,
    output logic [7:0]              sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            sum = sum + chunk[8*i +: 8];
        end
    end

endmodule

// File: rtl/payload_axis_packer.sv
// rtl/payload_axis_packer.sv - packs a flat message into an AXI4-Stream frame with optional checksum byte
// Ports: clk/resetn; msg_valid/msg_ready/msg_data message input; tvalid/tready/tdata/tkeep/tstrb/tlast
// AXIS master; busy (not idle); msg_count (frames completed, wrapping).
module payload_axis_packer
    import payload_pkg::*;
#(
    parameter int DATA_BYTES = 32,
    parameter int MSG_BYTES  = 79,
    parameter int CSUM_EN    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    msg_valid,
    output logic                    msg_ready,
    input  logic [8*MSG_BYTES-1:0]  msg_data,
    output logic                    tvalid,
    input  logic                    tready,
    output logic [8*DATA_BYTES-1:0] tdata,
    output logic [DATA_BYTES-1:0]   tkeep,
    output logic [DATA_BYTES-1:0]   tstrb,
    output logic                    tlast,
    output logic                    busy,
    output logic [CNT_W-1:0]        msg_count
);

    localparam int NBEATS     = calc_nbeats(MSG_BYTES, DATA_BYTES, CSUM_EN);
    localparam int LAST_BYTES = calc_last_bytes(MSG_BYTES, DATA_BYTES, CSUM_EN);
    localparam int DW         = 8 * DATA_BYTES;
    localparam int BUF_W      = NBEATS * DW;
    localparam int IDX_W      = (clog2(NBEATS) < 1) ? 1 : clog2(NBEATS);
    localparam logic [63:0]           KEEP64    = calc_last_keep(LAST_BYTES);
    localparam logic [DATA_BYTES-1:0] LAST_KEEP = KEEP64[DATA_BYTES-1:0];
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NBEATS - 1);
    // Kept in range when no checksum is appended so the write below always elaborates.
    localparam int CSUM_POS = (CSUM_EN != 0) ? 8 * MSG_BYTES : 0;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [7:0]         acc_q, acc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [DW-1:0]      tdata_q, tdata_d;
    logic [DATA_BYTES-1:0] tkeep_q, tkeep_d;
    logic [CNT_W-1:0]   msg_count_q, msg_count_d;

    logic [DW-1:0]      sum_chunk;
    logic [7:0]         chunk_sum;
    logic               load;

    assign sum_chunk = buf_q[32'(idx_q) * DW +: DW];

    payload_byte_sum #(.DATA_BYTES(DATA_BYTES)) u_byte_sum (
        .chunk (sum_chunk),
        .sum   (chunk_sum)
    );

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        msg_count_d = msg_count_q;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (msg_valid) begin
                    // Padding and checksum slot start at zero so they add nothing to the sum.
                    buf_d = '0;
                    buf_d[8*MSG_BYTES-1:0] = msg_data;
                    acc_d = '0;
                    idx_d = '0;
                    if (CSUM_EN != 0) begin
                        state_d = SUM;
                    end else begin
                        state_d = SEND;
                        load    = 1'b1;
                    end
                end
            end
            SUM: begin
                acc_d = acc_q + chunk_sum;
                if (idx_q == LAST_IDX) begin
                    if (CSUM_EN != 0) buf_d[CSUM_POS +: 8] = acc_d;
                    idx_d   = '0;
                    state_d = SEND;
                    load    = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SEND: begin
                if (tready) begin
                    if (idx_q == LAST_IDX) begin
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        tdata_d     = '0;
                        tkeep_d     = '0;
                        idx_d       = '0;
                        msg_count_d = msg_count_q + 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        load  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Beat registers are loaded from the next-state buffer so the freshly written
        // checksum is visible even on a single-beat frame.
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = buf_d[32'(idx_d) * DW +: DW];
            tlast_d  = (idx_d == LAST_IDX);
            tkeep_d  = tlast_d ? LAST_KEEP : '1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            msg_count_q <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            msg_count_q <= msg_count_d;
        end
    end

    assign msg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign tvalid    = tvalid_q;
    assign tdata     = tdata_q;
    assign tkeep     = tkeep_q;
    assign tstrb     = tkeep_q;
    assign tlast     = tlast_q;
    assign msg_count = msg_count_q;

endmodule

// File: tb/tb_payload_axis_packer.sv
// tb/tb_payload_axis_packer.sv - directed self-checking bench for payload_axis_packer
module tb_payload_axis_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic tready;

    // a: defaults (32-byte bus, 79-byte message, checksum)
    logic         a_msg_valid, a_msg_ready, a_tvalid, a_tlast, a_busy;
    logic [631:0] a_msg_data;
    logic [255:0] a_tdata;
    logic [31:0]  a_tkeep, a_tstrb;
    logic [15:0]  a_cnt;

    // b: 64-byte message with checksum
    logic         b_msg_valid, b_msg_ready, b_tvalid, b_tlast, b_busy;
    logic [511:0] b_msg_data;
    logic [255:0] b_tdata;
    logic [31:0]  b_tkeep, b_tstrb;
    logic [15:0]  b_cnt;

    // c: 64-byte message, no checksum
    logic         c_msg_valid, c_msg_ready, c_tvalid, c_tlast, c_busy;
    logic [511:0] c_msg_data;
    logic [255:0] c_tdata;
    logic [31:0]  c_tkeep, c_tstrb;
    logic [15:0]  c_cnt;

    payload_axis_packer u_a (
        .clk(clk), .resetn(resetn), .msg_valid(a_msg_valid), .msg_ready(a_msg_ready),
        .msg_data(a_msg_data), .tvalid(a_tvalid), .tready(tready), .tdata(a_tdata),
        .tkeep(a_tkeep), .tstrb(a_tstrb), .tlast(a_tlast), .busy(a_busy), .msg_count(a_cnt)
    );

    payload_axis_packer #(.DATA_BYTES(32), .MSG_BYTES(64), .CSUM_EN(1), .CNT_W(16)) u_b (
        .clk(clk), .resetn(resetn), .msg_valid(b_msg_valid), .msg_ready(b_msg_ready),
        .msg_data(b_msg_data), .tvalid(b_tvalid), .tready(tready), .tdata(b_tdata),
        .tkeep(b_tkeep), .tstrb(b_tstrb), .tlast(b_tlast), .busy(b_busy), .msg_count(b_cnt)
    );

    payload_axis_packer #(.DATA_BYTES(32), .MSG_BYTES(64), .CSUM_EN(0), .CNT_W(16)) u_c (
        .clk(clk), .resetn(resetn), .msg_valid(c_msg_valid), .msg_ready(c_msg_ready),
        .msg_data(c_msg_data), .tvalid(c_tvalid), .tready(tready), .tdata(c_tdata),
        .tkeep(c_tkeep), .tstrb(c_tstrb), .tlast(c_tlast), .busy(c_busy), .msg_count(c_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte k of message = k.
    function automatic logic [631:0] msg_ramp();
        logic [631:0] v;
        v = '0;
        for (int k = 0; k < 79; k++) v[8*k +: 8] = 8'(k);
        return v;
    endfunction

    // Expected beat b: payload byte (ramp k or 0xFF), then checksum byte at index msg, then zeros.
    function automatic logic [255:0] exp_beat(input int b, input int msg, input bit ramp, input logic [7:0] csum);
        logic [255:0] v;
        int k;
        v = '0;
        for (int j = 0; j < 32; j++) begin
            k = b * 32 + j;
            if (k < msg) v[8*j +: 8] = ramp ? 8'(k) : 8'hFF;
            else if (k == msg) v[8*j +: 8] = csum;
        end
        return v;
    endfunction

    task automatic chk_a_beat(input string tag, input int b, input bit ramp, input logic [7:0] csum);
        chk({tag, "_tvalid"}, a_tvalid, 1'b1);
        chk({tag, "_tdata"}, a_tdata, exp_beat(b, 79, ramp, csum));
        chk({tag, "_tkeep"}, a_tkeep, (b == 2) ? 32'h0000FFFF : 32'hFFFFFFFF);
        chk({tag, "_tstrb"}, a_tstrb, (b == 2) ? 32'h0000FFFF : 32'hFFFFFFFF);
        chk({tag, "_tlast"}, a_tlast, (b == 2) ? 1'b1 : 1'b0);
    endtask

    initial begin
        logic [631:0] ramp;
        ramp = msg_ramp();
        resetn = 1'b0;
        tready = 1'b1;
        a_msg_valid = 1'b0; a_msg_data = '0;
        b_msg_valid = 1'b0; b_msg_data = '0;
        c_msg_valid = 1'b0; c_msg_data = '0;
        #12;
        chk("rst_msg_ready", a_msg_ready, 1'b1);
        chk("rst_tvalid", a_tvalid, 1'b0);
        chk("rst_tlast", a_tlast, 1'b0);
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_count", a_cnt, 16'd0);
        resetn = 1'b1;
        tick();

        // Ramp message, continuous tready: checksum 0..78 sum = 3081 -> 0x09.
        a_msg_data = ramp;
        a_msg_valid = 1'b1;
        tick();
        a_msg_valid = 1'b0;
        chk("t1_busy", a_busy, 1'b1);
        chk("t1_ready_sum", a_msg_ready, 1'b0);
        chk("t1_lat0", a_tvalid, 1'b0);
        tick();
        chk("t1_lat1", a_tvalid, 1'b0);
        tick();
        chk("t1_lat2", a_tvalid, 1'b0);
        tick();
        chk_a_beat("t1_b0", 0, 1'b1, 8'h09);
        tick();
        chk_a_beat("t1_b1", 1, 1'b1, 8'h09);
        tick();
        chk_a_beat("t1_b2", 2, 1'b1, 8'h09);
        tick();
        chk("t1_end_tvalid", a_tvalid, 1'b0);
        chk("t1_end_tdata", a_tdata, 256'h0);
        chk("t1_end_tkeep", a_tkeep, 32'h0);
        chk("t1_count", a_cnt, 16'd1);
        chk("t1_ready", a_msg_ready, 1'b1);

        // New message offered mid-frame must wait; then it streams with a stall on beat1.
        a_msg_data = ramp;
        a_msg_valid = 1'b1;
        tick();
        a_msg_valid = 1'b0;
        tick(); tick(); tick();
        a_msg_data = {79{8'hFF}};
        a_msg_valid = 1'b1;
        chk("t6_ready_send", a_msg_ready, 1'b0);
        chk_a_beat("t6_a_b0", 0, 1'b1, 8'h09);
        tick();
        chk_a_beat("t6_a_b1", 1, 1'b1, 8'h09);
        tick();
        chk_a_beat("t6_a_b2", 2, 1'b1, 8'h09);
        tick();
        chk("t6_gap_tvalid", a_tvalid, 1'b0);
        chk("t6_gap_ready", a_msg_ready, 1'b1);
        chk("t6_count", a_cnt, 16'd2);
        tick();
        a_msg_valid = 1'b0;
        chk("t6_accept", a_busy, 1'b1);
        tick(); tick(); tick();
        chk_a_beat("t2_b0", 0, 1'b0, 8'hB1);
        tick();
        tready = 1'b0;
        chk_a_beat("t2_b1", 1, 1'b0, 8'hB1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a_beat("t2_stall", 1, 1'b0, 8'hB1);
        end
        tready = 1'b1;
        tick();
        chk_a_beat("t2_b2", 2, 1'b0, 8'hB1);
        tick();
        chk("t2_end_tvalid", a_tvalid, 1'b0);
        chk("t2_end_tlast", a_tlast, 1'b0);
        chk("t2_count", a_cnt, 16'd3);

        // Reset while beat1 is stalled.
        a_msg_data = ramp;
        a_msg_valid = 1'b1;
        tick();
        a_msg_valid = 1'b0;
        tick(); tick(); tick();
        tick();
        tready = 1'b0;
        tick();
        chk("t3_pre_tvalid", a_tvalid, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t3_rst_tvalid", a_tvalid, 1'b0);
        chk("t3_rst_tlast", a_tlast, 1'b0);
        chk("t3_rst_tdata", a_tdata, 256'h0);
        chk("t3_rst_ready", a_msg_ready, 1'b1);
        chk("t3_rst_count", a_cnt, 16'd0);
        tready = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        chk("t3_rel_ready", a_msg_ready, 1'b1);
        chk("t3_rel_tvalid", a_tvalid, 1'b0);
        a_msg_data = {79{8'hFF}};
        a_msg_valid = 1'b1;
        tick();
        a_msg_valid = 1'b0;
        tick(); tick(); tick();
        chk_a_beat("t3_b0", 0, 1'b0, 8'hB1);
        tick();
        chk_a_beat("t3_b1", 1, 1'b0, 8'hB1);
        tick();
        chk_a_beat("t3_b2", 2, 1'b0, 8'hB1);
        tick();
        chk("t3_count", a_cnt, 16'd1);

        // 64 bytes of 0x01 with checksum: 3 beats, last carries only 0x40.
        b_msg_data = {64{8'h01}};
        b_msg_valid = 1'b1;
        tick();
        b_msg_valid = 1'b0;
        tick(); tick(); tick();
        chk("t4_b0_tvalid", b_tvalid, 1'b1);
        chk("t4_b0_tdata", b_tdata, {32{8'h01}});
        chk("t4_b0_tlast", b_tlast, 1'b0);
        tick();
        chk("t4_b1_tdata", b_tdata, {32{8'h01}});
        chk("t4_b1_tkeep", b_tkeep, 32'hFFFFFFFF);
        tick();
        chk("t4_b2_tdata", b_tdata, 256'h40);
        chk("t4_b2_tkeep", b_tkeep, 32'h00000001);
        chk("t4_b2_tstrb", b_tstrb, 32'h00000001);
        chk("t4_b2_tlast", b_tlast, 1'b1);
        tick();
        chk("t4_end_tvalid", b_tvalid, 1'b0);
        chk("t4_count", b_cnt, 16'd1);

        // No checksum, msg_valid held: frames every 3 cycles, 300 frames.
        c_msg_data = ramp[511:0];
        c_msg_valid = 1'b1;
        tick();
        chk("t5_b0_tvalid", c_tvalid, 1'b1);
        chk("t5_b0_tdata", c_tdata, exp_beat(0, 64, 1'b1, 8'h00));
        chk("t5_b0_tlast", c_tlast, 1'b0);
        chk("t5_b0_tkeep", c_tkeep, 32'hFFFFFFFF);
        tick();
        chk("t5_b1_tdata", c_tdata, exp_beat(1, 64, 1'b1, 8'h00));
        chk("t5_b1_tkeep", c_tkeep, 32'hFFFFFFFF);
        chk("t5_b1_tlast", c_tlast, 1'b1);
        tick();
        chk("t5_gap_tvalid", c_tvalid, 1'b0);
        chk("t5_gap_ready", c_msg_ready, 1'b1);
        chk("t5_count1", c_cnt, 16'd1);
        tick();
        chk("t5_f2_tvalid", c_tvalid, 1'b1);
        chk("t5_f2_tdata", c_tdata, exp_beat(0, 64, 1'b1, 8'h00));
        for (int i = 0; i < 896; i++) tick();
        c_msg_valid = 1'b0;
        chk("t5_count300", c_cnt, 16'd300);
        tick(); tick();
        chk("t5_idle_tvalid", c_tvalid, 1'b0);
        chk("t5_idle_busy", c_busy, 1'b0);
        chk("t5_count_final", c_cnt, 16'd300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
